// File: rtl/cla_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : cla_pkg
//  Purpose  : Constants and the result record shared by the CLA result path.
//             Covers the 16-bit adder width, its pipeline depth and the
//             {ovf, sum} record the adder produces.
//  Revision : 1.0  initial release
// ============================================================================
package cla_pkg;

    localparam int CLA_WIDTH = 16;
    localparam int CLA_LAT   = 2;

    typedef struct packed {
        logic                 ovf;
        logic [CLA_WIDTH-1:0] sum;
    } cla_result_t;

endpackage : cla_pkg
`default_nettype wire

// File: rtl/cla_result_fifo_if.sv
`default_nettype none
// ============================================================================
//  Module   : cla_result_fifo_if
//  Purpose  : Bundle of the issue-side, adder-side and consumer-side signals
//             of the CLA result FIFO. The master modport is the surrounding
//             system: issuer, adder and consumer. The slave modport is the
//             FIFO block.
//  Revision : 1.0  initial release
// ============================================================================
interface cla_result_fifo_if
    import cla_pkg::*;
#(
    parameter int WIDTH = CLA_WIDTH,
    parameter int DEPTH = 4
);
    localparam int c_cnt_w = $clog2(DEPTH) + 1;

    logic               in_valid;
    logic               issue_ready;
    logic [WIDTH-1:0]   sum_in;
    logic               ovf_in;
    logic               out_valid;
    logic               out_ready;
    logic [WIDTH-1:0]   out_sum;
    logic               out_ovf;
    logic [c_cnt_w-1:0] count;
    logic [7:0]         ovf_count;

    modport master (
        output in_valid, sum_in, ovf_in, out_ready,
        input  issue_ready, out_valid, out_sum, out_ovf, count, ovf_count
    );

    modport slave (
        input  in_valid, sum_in, ovf_in, out_ready,
        output issue_ready, out_valid, out_sum, out_ovf, count, ovf_count
    );

endinterface : cla_result_fifo_if
`default_nettype wire

// File: rtl/cla_valid_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : cla_valid_pipe
//  Purpose  : LAT-deep shift register of issue flags. It runs in lock-step
//             with the adder pipeline. tail marks the cycle whose adder
//             output belongs to an issued op. inflight counts issued ops not
//             yet captured.
//  Revision : 1.0  initial release
// ============================================================================
module cla_valid_pipe #(
    parameter int LAT = 2
) (
    input  wire logic                       clk,
    input  wire logic                       rst_n,
    input  wire logic                       issue,
    output logic                            tail,
    output logic [$clog2(LAT+1)-1:0]        inflight
);
    localparam int c_cnt_w = $clog2(LAT + 1);

    logic [LAT-1:0]     r_pipe;
    logic [c_cnt_w-1:0] w_cnt;

    generate
        if (LAT == 1) begin : g_lat_one
            // Single-stage pipe: the issue flag itself is the tail next cycle.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) r_pipe <= '0;
                else        r_pipe <= issue;
            end
        end else begin : g_lat_multi
            // Shift issue flags toward the tail, one stage per clock.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) r_pipe <= '0;
                else        r_pipe <= {r_pipe[LAT-2:0], issue};
            end
        end
    endgenerate

    // Popcount of the pipe: ops issued but not yet pushed into the FIFO.
    always_comb begin
        w_cnt = '0;
        for (int i = 0; i < LAT; i++) begin
            w_cnt = w_cnt + c_cnt_w'(r_pipe[i]);
        end
    end

    assign tail     = r_pipe[LAT-1];
    assign inflight = w_cnt;

endmodule : cla_valid_pipe
`default_nettype wire

// File: rtl/cla_result_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : cla_result_fifo
//  Purpose  : Captures pipelined CLA adder results {ovf, sum} into a small
//             first-word-fall-through FIFO. The FIFO feeds a valid/ready
//             consumer. issue_ready is credit-based, so the non-stallable
//             adder can never overrun the FIFO.
//             Optional: define CLA_RES_OVFCNT_EN to enable the saturating
//             overflow counter on ovf_count; otherwise ovf_count reads 0.
//  Revision : 1.0  initial release
// ============================================================================
module cla_result_fifo
    import cla_pkg::*;
#(
    parameter int WIDTH = CLA_WIDTH,
    parameter int LAT   = CLA_LAT,
    parameter int DEPTH = 4
) (
    input  wire logic        clk,
    input  wire logic        rst_n,
    cla_result_fifo_if.slave bus
);
    localparam int c_aw    = $clog2(DEPTH);
    localparam int c_cw    = c_aw + 1;
    localparam int c_lw    = $clog2(LAT + 1);

    logic [WIDTH:0]     r_mem [DEPTH];
    logic [c_aw-1:0]    r_wr_ptr;
    logic [c_aw-1:0]    r_rd_ptr;
    logic [c_cw-1:0]    r_count;
    logic [WIDTH:0]     r_last;

    logic               w_tail;
    logic [c_lw-1:0]    w_inflight;
    logic [31:0]        w_credit;
    logic               w_issue_ready;
    logic               w_issue;
    logic               w_push;
    logic               w_pop;
    logic               w_not_empty;
    logic [WIDTH:0]     w_head;

    // Stored entries plus results still inside the adder must fit in the FIFO.
    assign w_credit      = 32'(r_count) + 32'(w_inflight);
    assign w_issue_ready = (w_credit < 32'(DEPTH));
    assign w_issue       = bus.in_valid && w_issue_ready;
    assign w_push        = w_tail;
    assign w_not_empty   = (r_count != '0);
    assign w_pop         = bus.out_ready && w_not_empty;

    cla_valid_pipe #(
        .LAT      (LAT)
    ) u_valid_pipe (
        .clk      (clk),
        .rst_n    (rst_n),
        .issue    (w_issue),
        .tail     (w_tail),
        .inflight (w_inflight)
    );

    // Result storage; the credit rule guarantees a free slot on every push.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= {bus.ovf_in, bus.sum_in};
    end

    // Pointers, occupancy and the last popped value held while empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_last   <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + c_aw'(1);
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_aw'(1);
                r_last   <= r_mem[r_rd_ptr];
            end
            if (w_push && !w_pop)      r_count <= r_count + c_cw'(1);
            else if (!w_push && w_pop) r_count <= r_count - c_cw'(1);
        end
    end

    // No bypass: a push into an empty FIFO shows up on the next cycle.
    assign w_head = w_not_empty ? r_mem[r_rd_ptr] : r_last;

    assign bus.issue_ready = w_issue_ready;
    assign bus.out_valid   = w_not_empty;
    assign bus.out_sum     = w_head[WIDTH-1:0];
    assign bus.out_ovf     = w_head[WIDTH];
    assign bus.count       = r_count;

`ifdef CLA_RES_OVFCNT_EN
    logic [7:0] r_ovf_count;

    // Saturating count of captured results that carried an overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                            r_ovf_count <= 8'h00;
        else if (w_push && bus.ovf_in && r_ovf_count != 8'hFF) r_ovf_count <= r_ovf_count + 8'd1;
    end

    assign bus.ovf_count = r_ovf_count;
`else
    assign bus.ovf_count = 8'h00;
`endif

endmodule : cla_result_fifo
`default_nettype wire

// File: tb/tb_cla_result_fifo.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_cla_result_fifo
//  Purpose  : Self-checking bench for cla_result_fifo. A behavioural adder
//             feeds the block. A queue-based model predicts every output on
//             each cycle, and directed literal checks pin down the model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_cla_result_fifo;
    import cla_pkg::*;

    localparam int WIDTH = CLA_WIDTH;
    localparam int LAT   = CLA_LAT;
    localparam int DEPTH = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    cla_result_fifo_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

    cla_result_fifo #(
        .WIDTH (WIDTH),
        .LAT   (LAT),
        .DEPTH (DEPTH)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // ---------------- behavioural adder: C_in = 0, Of = carry out ----------
    logic [WIDTH-1:0] op_a = '0;
    logic [WIDTH-1:0] op_b = '0;
    logic [WIDTH:0]   add_pipe [LAT];

    always @(posedge clk) begin
        add_pipe[0] <= {1'b0, op_a} + {1'b0, op_b};
        for (int k = 1; k < LAT; k++) add_pipe[k] <= add_pipe[k-1];
    end
    assign bus.sum_in = add_pipe[LAT-1][WIDTH-1:0];
    assign bus.ovf_in = add_pipe[LAT-1][WIDTH];

    // ---------------- scoreboard counters ----------------------------------
    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    endtask

    // ---------------- reference model --------------------------------------
    typedef struct {
        int unsigned stamp;
        cla_result_t r;
    } fl_t;

    cla_result_t mq[$];       // results stored in the FIFO, head first
    fl_t         fl[$];       // accepted ops still inside the adder
    cla_result_t m_last;      // value shown while empty
    int          m_ovf;
    int unsigned cyc = 0;     // edge counter

    function automatic bit m_ready();
        return (mq.size() + fl.size()) < DEPTH;
    endfunction

    task automatic model_clear();
        mq.delete();
        fl.delete();
        m_last = '0;
        m_ovf  = 0;
    endtask

    // Advance the model by one clock edge using the inputs applied for it.
    task automatic model_edge();
        bit          iss;
        fl_t         f;
        cla_result_t nr;
        cyc++;
        iss = bus.in_valid && m_ready();
        if (bus.out_ready && mq.size() > 0) m_last = mq.pop_front();
        if (fl.size() > 0 && fl[0].stamp + LAT == cyc) begin
            f  = fl.pop_front();
            nr = f.r;
            mq.push_back(nr);
`ifdef CLA_RES_OVFCNT_EN
            if (nr.ovf && m_ovf < 255) m_ovf++;
`endif
        end
        if (iss) begin
            f.stamp = cyc;
            f.r     = {1'b0, op_a} + {1'b0, op_b};
            fl.push_back(f);
        end
    endtask

    // ---------------- per-cycle compare process ----------------------------
    bit          chk_en   = 1'b0;
    bit          lit_mode = 1'b0;
    int          lit_idx  = 0;
    int unsigned lit_base = 0;
    cla_result_t cmp_h;

    logic [16:0] lit_r [5] = '{17'h166ab, 17'h0c58a, 17'h09dea, 17'h05555, 17'h0ffff};
    logic [15:0] lit_a [5] = '{16'haacd, 16'h0006, 16'h063f, 16'h1234, 16'h6789};
    logic [15:0] lit_b [5] = '{16'hbbde, 16'hc584, 16'h97ab, 16'h4321, 16'h9876};

    always @(negedge clk) begin
        if (chk_en) begin
            cmp_h = (mq.size() != 0) ? mq[0] : m_last;
            chk("out_valid",   32'(bus.out_valid),   32'(mq.size() != 0));
            chk("out_sum",     32'(bus.out_sum),     32'(cmp_h.sum));
            chk("out_ovf",     32'(bus.out_ovf),     32'(cmp_h.ovf));
            chk("count",       32'(bus.count),       32'(mq.size()));
            chk("issue_ready", 32'(bus.issue_ready), 32'(m_ready()));
            chk("ovf_count",   32'(bus.ovf_count),   32'(m_ovf));
        end
        if (lit_mode && bus.out_valid) begin
            if (lit_idx < 5) begin
                chk("lit_sum",     32'({bus.out_ovf, bus.out_sum}), 32'(lit_r[lit_idx]));
                chk("lit_latency", cyc, lit_base + 32'(lit_idx) + LAT);
            end
            lit_idx++;
        end
    end

    // ---------------- stimulus helpers -------------------------------------
    task automatic tick(input bit v, input logic [15:0] a, input logic [15:0] b, input bit rdy);
        @(negedge clk);
        bus.in_valid  = v;
        op_a          = a;
        op_b          = b;
        bus.out_ready = rdy;
        @(posedge clk);
        model_edge();
    endtask

    // Reset asserted between edges so the asynchronous clear is observable.
    task automatic apply_reset();
        chk_en        = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_out_valid",   32'(bus.out_valid),   32'h0);
        chk("rst_count",       32'(bus.count),       32'h0);
        chk("rst_issue_ready", 32'(bus.issue_ready), 32'h1);
        chk("rst_out_sum",     32'(bus.out_sum),     32'h0);
        chk("rst_out_ovf",     32'(bus.out_ovf),     32'h0);
        chk("rst_ovf_count",   32'(bus.ovf_count),   32'h0);
        model_clear();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n  = 1'b1;
        chk_en = 1'b1;
    endtask

    // ---------------- main sequence ----------------------------------------
    initial begin
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        model_clear();
        apply_reset();

        // Directed pairs, back-to-back, consumer always ready.
        lit_idx  = 0;
        lit_base = cyc + 1;
        lit_mode = 1'b1;
        for (int i = 0; i < 5; i++) tick(1'b1, lit_a[i], lit_b[i], 1'b1);
        repeat (6) tick(1'b0, 16'h0, 16'h0, 1'b1);
        lit_mode = 1'b0;
        chk("lit_all_seen", 32'(lit_idx), 32'd5);

        // Consumer stalled, issuer keeps pushing: credit must stop at DEPTH.
        for (int i = 0; i < 10; i++) tick(1'b1, 16'(16'h1000 * i + 1), 16'(16'h0f0f + i), 1'b0);
        #1;
        chk("stall_count_full",  32'(bus.count),       32'd4);
        chk("stall_ready_low",   32'(bus.issue_ready), 32'd0);
        repeat (8) tick(1'b0, 16'h0, 16'h0, 1'b1);

        // Continuous issue with ready consumer; exercises pointer wrap.
        for (int i = 0; i < 24; i++) tick(1'b1, 16'($urandom), 16'($urandom), 1'b1);
        repeat (6) tick(1'b0, 16'h0, 16'h0, 1'b1);

        // Randomized traffic, including issue attempts while not ready
        // and pops while empty.
        for (int i = 0; i < 500; i++)
            tick($urandom_range(0, 3) != 0, 16'($urandom), 16'($urandom), $urandom_range(0, 1) == 1);
        repeat (8) tick(1'b0, 16'h0, 16'h0, 1'b1);

        // Mid-stream reset with two stored and two in flight.
        for (int i = 0; i < 4; i++) tick(1'b1, 16'hf000, 16'(16'h1111 * (i + 1)), 1'b0);
        #1;
        chk("mid_count_two", 32'(bus.count),       32'd2);
        chk("mid_ready_low", 32'(bus.issue_ready), 32'd0);
        apply_reset();
        repeat (6) tick(1'b0, 16'h0, 16'h0, 1'b1);

        // Overflow counter: 300 carries out of ffff + 0001.
        for (int i = 0; i < 300; i++) tick(1'b1, 16'hffff, 16'h0001, 1'b1);
        repeat (6) tick(1'b0, 16'h0, 16'h0, 1'b1);
        #1;
`ifdef CLA_RES_OVFCNT_EN
        chk("ovf_count_sat", 32'(bus.ovf_count), 32'h0000_00ff);
`else
        chk("ovf_count_off", 32'(bus.ovf_count), 32'h0000_0000);
`endif

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule : tb_cla_result_fifo
`default_nettype wire

// File: doc/cla_result_fifo.md
Name: cla_result_fifo

Overview:
- Downstream stage of the pipelined 16-bit CLA adder (CLAout).
- Aligns issue-side valid with the adder's fixed pipeline latency and captures each {Of, O} result into a small first-word-fall-through FIFO.
- Presents results to a valid/ready consumer.
- Generates credit-based backpressure (issue_ready) so the upstream operand issuer never overruns the FIFO, since the adder itself cannot stall.

Parameters:
- WIDTH, 16, sum width; must match adder O width.
- LAT, 2, adder pipeline depth in clk cycles from M/N/C_in sample to O/Of valid; LAT >= 1.
- DEPTH, 4, FIFO entries; power of two, >= 2.

Ports:
- clk  in  1  rising-edge clock shared with adder.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operands presented to adder this cycle (issue qualifier).
- issue_ready  out  1  upstream may assert in_valid this cycle.
- sum_in  in  WIDTH  adder O.
- ovf_in  in  1  adder Of.
- out_valid  out  1  FIFO head valid.
- out_ready  in  1  consumer accepts head.
- out_sum  out  WIDTH  head sum.
- out_ovf  out  1  head overflow flag.
- count  out  $clog2(DEPTH)+1  stored entries.
- ovf_count  out  8  results captured with ovf_in=1 (see Optional Feature).

Behaviour:
- Reset (async assert, sync release): valid delay line cleared, FIFO empty, wr/rd pointers 0, count=0, out_valid=0, out_sum=0, out_ovf=0, ovf_count=0, issue_ready=1.
- Issue: an op is issued when in_valid && issue_ready. in_valid while issue_ready=0 is an upstream protocol error; the op is dropped, not captured.
- Delay line: LAT-bit shift register of issued flags; inflight = popcount of the delay line.
- Capture: when the delay-line tail is 1, push {ovf_in, sum_in} sampled that same edge. Latency is issue edge + LAT edges to push, and out_valid rises the cycle after the push.
- Credit: issue_ready = (count + inflight) < DEPTH, combinational from registered state. This rule makes the FIFO impossible to overflow; no push is ever refused.
- Pop: on out_ready && out_valid, advance rd_ptr. out_ready while empty is ignored.
- FWFT: out_sum/out_ovf drive the mem[rd_ptr] entry whenever out_valid=1. When empty they hold the last popped value (0 after reset).
- Simultaneous push and pop:
  - Count unchanged.
  - When full, both proceed.
  - When empty, the popped entry is the old head. Bypass is not allowed, so a push into an empty FIFO becomes visible next cycle.
- Pointers wrap modulo DEPTH. count saturates by construction at DEPTH.
- Reset mid-operation: in-flight adder results are discarded. Adder outputs arriving after reset release are ignored because the delay line is cleared.

Optional Feature:
- Macro CLA_RES_OVFCNT_EN.
- Defined: ovf_count increments on each push with ovf_in=1 and saturates at 8'hFF. It is not cleared except by reset.
- Undefined: the counter logic is absent and ovf_count is tied to 8'h00. Port list is unchanged.

Decomposition:
- Shared package cla_pkg:
  - CLA_WIDTH=16 and CLA_LAT constants.
  - Result typedef/struct {ovf, sum[CLA_WIDTH-1:0]}.
- Sub-module cla_valid_pipe: LAT-deep valid shift register with async reset, outputs tail and inflight count.
- FIFO storage and pointers stay in cla_result_fifo.

Test Plan:
- Issue back-to-back with C_in=0 and out_ready=1:
  - Pairs aacd+bbde, 0006+c584, 063f+97ab, 1234+4321, 6789+9876.
  - Expect in order {1,66ab}, {0,c58a}, {0,9dea}, {0,5555}, {0,ffff}.
  - Each out_valid appears LAT+1 cycles after its issue.
- out_ready=0, issue continuously:
  - issue_ready drops when count+inflight=4.
  - Exactly 4 entries stored, count=4.
  - No data lost after releasing out_ready.
- Full FIFO with out_ready=1 and in_valid=1 every cycle:
  - Steady state is one push and one pop per cycle, count stays constant.
  - Pointers wrap past 3→0 with correct ordering over 12 results.
- Assert rst_n=0 mid-stream with 2 entries stored and 2 in flight:
  - All outputs return to reset values immediately (asynchronously).
  - No stale results appear after release.
- With CLA_RES_OVFCNT_EN:
  - 300 issues of ffff+0001 give ovf_count=8'hFF (saturated).
  - Without the macro, ovf_count=0.
- Protocol checks:
  - in_valid asserted while issue_ready=0 produces no capture.
  - out_ready asserted while empty leaves pointers unchanged.
